// File: rtl/snowflake_pkg.sv
// Shared constants, reader state encoding and the cell colour mapping used by
// the snowflake solver and its column reader.
package snowflake_pkg;

  localparam int DATA_W = 18;
  localparam int FRAC_W = 16;
  localparam logic [DATA_W-1:0] ONE = 18'h10000;

  localparam logic [7:0] COLOR_FROZEN = 8'hFF;
  localparam logic [7:0] COLOR_NEG    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_FINISH
  } reader_state_t;

  // s is u + v with one guard bit, so it is compared against ONE as a signed value.
  function automatic logic is_frozen(input logic signed [DATA_W:0] s);
    return s >= $signed({1'b0, ONE});
  endfunction

  // Frozen -> white, negative -> black, otherwise a grey ramp from the top fraction bits.
  function automatic logic [7:0] color_map(input logic signed [DATA_W:0] s);
    if (is_frozen(s)) begin
      return COLOR_FROZEN;
    end else if (s[DATA_W]) begin
      return COLOR_NEG;
    end else begin
      return {s[FRAC_W-1 -: 3], s[FRAC_W-1 -: 3], s[FRAC_W-1 -: 2]};
    end
  endfunction

endpackage

// File: rtl/snowflake_column_reader_if.sv
// Pixel-write stream from the column reader to the VGA framebuffer writer.
interface snowflake_column_reader_if;

  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_color;

  modport master (
    output pix_valid,
    output pix_x,
    output pix_y,
    output pix_color,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_x,
    input  pix_y,
    input  pix_color,
    output pix_ready
  );

endinterface

// File: rtl/snowflake_column_reader_pixel_skid_fifo.sv
// Two-entry synchronous FIFO holding {addr, colour} pixel words while the
// framebuffer writer stalls. Push and pop in the same cycle are allowed at
// any occupancy, including push while full if a pop happens too.
module pixel_skid_fifo #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/snowflake_column_reader.sv
// Scans one column of u_curr/v_next cells after a solver pass, colour-maps
// s = u + v per cell and streams the pixels to the framebuffer writer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | solver owns the read ports, waiting for start
// ST_SCAN   | issuing reads while skid FIFO + in-flight read leave room
// ST_DRAIN  | all reads issued, emitting the remaining pixels
// ST_FINISH | done pulse, publish frozen tally
//
// Read data is mapped in the cycle it returns. When the FIFO is empty the
// fresh pixel is offered straight to the stream and only captured in the
// FIFO if the writer stalls, so the first pixel appears two cycles after the
// accepted start.
module snowflake_column_reader #(
  parameter int NUM_CELLS = 11,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 18,
  parameter int Y_BASE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [9:0]            col_x,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data_u,
  input  logic [DATA_W-1:0]     rd_data_v,
  snowflake_column_reader_if.master pix,
  output logic [ADDR_W-1:0]     frozen_count
);

  import snowflake_pkg::*;

  localparam int FIFO_W = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  reader_state_t         state_q, state_d;
  logic [9:0]            col_x_q, col_x_d;
  logic [ADDR_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]     emit_cnt_q, emit_cnt_d;
  logic [ADDR_W-1:0]     tally_q, tally_d;
  logic [ADDR_W-1:0]     frozen_count_q, frozen_count_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  issue;
  logic [1:0]            pending;
  logic signed [DATA_W:0] sum;
  logic [7:0]            in_color;
  logic                  frozen_in;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]            fifo_count;
  logic [FIFO_W-1:0]     fifo_dout;
  logic [ADDR_W-1:0]     head_addr;
  logic [7:0]            head_color;
  logic                  pix_hs;

  // rd_addr_q always names the most recent read, which is the one in flight.
  pixel_skid_fifo #(.W(FIFO_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({rd_addr_q, in_color}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read issue, cell mapping and stream head selection.
  always_comb begin
    pending   = fifo_count + {1'b0, rd_valid_q};
    issue     = (state_q == ST_SCAN) && (pending < 2'd2);
    rd_addr   = issue ? issue_cnt_q : rd_addr_q;
    rd_addr_d = rd_addr;
    rd_valid_d = issue;

    sum       = $signed({rd_data_u[DATA_W-1], rd_data_u}) +
                $signed({rd_data_v[DATA_W-1], rd_data_v});
    in_color  = color_map(sum);
    frozen_in = rd_valid_q && is_frozen(sum);

    pix.pix_valid = !fifo_empty || rd_valid_q;
    head_addr  = '0;
    head_color = '0;
    if (!fifo_empty) begin
      head_addr  = fifo_dout[FIFO_W-1:8];
      head_color = fifo_dout[7:0];
    end else if (rd_valid_q) begin
      head_addr  = rd_addr_q;
      head_color = in_color;
    end
    pix.pix_x     = pix.pix_valid ? col_x_q : 10'd0;
    pix.pix_y     = pix.pix_valid ? 10'(head_addr + ADDR_W'(Y_BASE)) : 10'd0;
    pix.pix_color = head_color;

    pix_hs    = pix.pix_valid && pix.pix_ready;
    fifo_pop  = !fifo_empty && pix.pix_ready;
    fifo_push = rd_valid_q && !(fifo_empty && pix.pix_ready) && (!fifo_full || fifo_pop);
  end

  // Sequencer next-state and counters.
  always_comb begin
    state_d        = state_q;
    col_x_d        = col_x_q;
    issue_cnt_d    = issue_cnt_q;
    emit_cnt_d     = emit_cnt_q;
    tally_d        = tally_q;
    frozen_count_d = frozen_count_q;
    if (pix_hs) begin
      emit_cnt_d = emit_cnt_q + ADDR_W'(1);
    end
    if (frozen_in) begin
      tally_d = tally_q + ADDR_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          col_x_d     = col_x;
          issue_cnt_d = '0;
          emit_cnt_d  = '0;
          tally_d     = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + ADDR_W'(1);
          if (issue_cnt_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pix_hs && (emit_cnt_q == LAST_ADDR)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        frozen_count_d = tally_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      col_x_q        <= '0;
      issue_cnt_q    <= '0;
      emit_cnt_q     <= '0;
      tally_q        <= '0;
      frozen_count_q <= '0;
      rd_addr_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_x_q        <= col_x_d;
      issue_cnt_q    <= issue_cnt_d;
      emit_cnt_q     <= emit_cnt_d;
      tally_q        <= tally_d;
      frozen_count_q <= frozen_count_d;
      rd_addr_q      <= rd_addr_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  assign busy         = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_FINISH);
  assign frozen_count = frozen_count_q;

endmodule
